ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
PS/2 keyboard receiver sitting directly behind the board's PS2_CLK/PS2_DATA pins, inside the mycom top level. It feeds the MZ-80A keyboard matrix emulation.
- Synchronises and deglitches the PS/2 lines.
- Deserialises 11-bit device-to-host frames and checks odd parity.
- Folds E0/F0 prefix bytes into flags.
- Presents one decoded scancode per key event with a single-cycle strobe.

Parameters:
FILTER_LEN, 8, number of consecutive identical CLK samples needed before the filtered PS2_CLK changes state (range 2..16).
TIMEOUT_CYC, 50000, watchdog limit in CLK cycles with no filtered clock edge while mid-frame (1 ms at 50 MHz); used only with PS2_RX_TIMEOUT_EN.

Ports:
CLK  input  1  system clock (50 MHz in mycom)
RST_N  input  1  asynchronous active-low reset
PS2_CLK  input  1  raw PS/2 clock pin, idle high
PS2_DATA  input  1  raw PS/2 data pin, idle high
CODE  output  8  last completed scancode (prefixes stripped)
BREAK  output  1  CODE was preceded by F0 (key release)
EXTEND  output  1  CODE was preceded by E0
VALID  output  1  one-cycle strobe: CODE/BREAK/EXTEND updated this cycle
PERR  output  1  one-cycle strobe: frame rejected (parity, start/stop, timeout)
BUSY  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset: one clock, asynchronous active-low reset (RST_N); CLK rising edge only.
  - CODE=0x00, BREAK=0, EXTEND=0, VALID=0, PERR=0, BUSY=0.
  - Sync and filter registers reset to 1 (idle high). Prefix flags cleared, state IDLE.
  - Reset mid-frame discards all partial data; no strobe is issued.
- Input conditioning:
  - 2-FF synchroniser on both pins.
  - PS2_CLK filter: the filtered level changes only after FILTER_LEN consecutive samples differ from the current level.
  - Sample event = filtered clock 1->0. PS2_DATA is taken from the synchronised data in that same cycle.
- FSM advances only on sample events:
  - IDLE: data 0 -> DATA, bit count=0. Data 1 -> stay in IDLE, no strobe (spurious edge).
  - DATA: shift right, new bit into bit7 (LSB first). After the 8th bit -> PARITY.
  - PARITY: latch the bit -> STOP.
  - STOP: always -> IDLE. The frame is good if stop==1 and the XOR of 8 data bits plus parity is 1.
- Good-frame byte handling, applied the cycle after the STOP sample:
  - 0xE0: set ext flag; no VALID.
  - 0xF0: set brk flag; no VALID.
  - Any other byte: CODE<=byte, BREAK<=brk, EXTEND<=ext, VALID=1 for exactly one cycle, both flags cleared.
- Bad frame: PERR=1 for one cycle, both flags cleared, CODE/BREAK/EXTEND unchanged.
- VALID and PERR are never asserted together.
- Latency: VALID/PERR rises no more than FILTER_LEN+4 CLK cycles after the pin-level falling edge of the 11th PS/2 clock.
- BUSY: 1 from the start-bit sample through the STOP sample, 0 the cycle after.
- Flags persist across IDLE time indefinitely. E0 followed by F0 sets both flags.
- Repeated prefixes (e.g. F0 F0) are idempotent.
- Host-to-device transmission is not supported. The block never drives the pins.

Optional Feature:
PS2_RX_TIMEOUT_EN:
- Defined: a counter runs while BUSY=1 and clears on every sample event. On reaching TIMEOUT_CYC it forces IDLE, pulses PERR for one cycle and clears the prefix flags. The next start bit is accepted normally.
- Undefined: no counter; a truncated frame holds BUSY=1 until further clock edges or reset. TIMEOUT_CYC is ignored.

Test Plan:
- Frame 0x1C (start 0; data 0,0,1,1,1,0,0,0; parity 0; stop 1), 40-cycle PS/2 half-periods -> one VALID, CODE=0x1C, BREAK=0, EXTEND=0, PERR never high.
- Frames F0,1C -> exactly one VALID, after the second frame: CODE=0x1C, BREAK=1, EXTEND=0. Following 0x1C frame -> BREAK=0.
- Frames E0,F0,75 -> single VALID with CODE=0x75, BREAK=1, EXTEND=1.
- Frame 0x1C with parity 1, then 0x1C with stop 0 -> two PERR pulses, no VALID, CODE keeps its prior value. Following good 0x32 -> VALID, CODE=0x32.
- 3-cycle low glitches on PS2_CLK (FILTER_LEN=8) between and inside a 0x1C frame -> no extra bits, CODE=0x1C decoded correctly.
- Start + 4 data bits then silence. With PS2_RX_TIMEOUT_EN and TIMEOUT_CYC=1000: PERR at 1000±2 cycles after the last edge, BUSY=0, next 0x1C decodes. Same stimulus with RST_N pulsed low mid-frame: all outputs return to reset values immediately.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver (sync, clock deglitch, 11-bit frame decode, E0/F0 prefix folding); optional watchdog via PS2_RX_TIMEOUT_EN
module ps2_kbd_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] CODE,
  output logic       BREAK,
  output logic       EXTEND,
  output logic       VALID,
  output logic       PERR,
  output logic       BUSY
);
  localparam int FW = $clog2(FILTER_LEN);
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;
  state_t r_state, w_next;
  logic [1:0]    r_clk_s, r_dat_s;
  logic          r_clk_f, r_clk_fd;
  logic [FW-1:0] r_fcnt;
  logic [7:0]    r_shift, r_code;
  logic [2:0]    r_bitcnt;
  logic          r_par, r_brk, r_ext, r_break, r_extend, r_valid, r_perr;
  logic          w_sample, w_dat, w_timeout, w_busy, w_end, w_good;
  assign w_sample = r_clk_fd & ~r_clk_f;
  assign w_dat    = r_dat_s[1];
  assign CODE     = r_code;
  assign BREAK    = r_break;
  assign EXTEND   = r_extend;
  assign VALID    = r_valid;
  assign PERR     = r_perr;
  assign BUSY     = w_busy;
  // synchronise both pins and let the clock level change only after FILTER_LEN agreeing samples
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_clk_s  <= 2'b11;
      r_dat_s  <= 2'b11;
      r_clk_f  <= 1'b1;
      r_clk_fd <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_clk_s  <= {r_clk_s[0], PS2_CLK};
      r_dat_s  <= {r_dat_s[0], PS2_DATA};
      r_clk_fd <= r_clk_f;
      if (r_clk_s[1] == r_clk_f) r_fcnt <= '0;
      else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_clk_f <= ~r_clk_f;
        r_fcnt  <= '0;
      end else r_fcnt <= r_fcnt + 1'b1;
    end
  end
`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_to_cnt;
  assign w_timeout = w_busy && !w_sample && r_to_cnt == TW'(TIMEOUT_CYC - 1);
  // watchdog: counts idle cycles between sample events while a frame is open
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_to_cnt <= '0;
    else r_to_cnt <= (!w_busy || w_sample || w_timeout) ? '0 : r_to_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0 && (TIMEOUT_CYC > 0);
`endif
  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // next state: advance only on sample events; the watchdog overrides
  always_comb begin
    w_next = w_timeout ? S_IDLE :
             !w_sample ? r_state :
             r_state == S_IDLE ? (w_dat ? S_IDLE : S_DATA) :
             r_state == S_DATA ? (r_bitcnt == 3'd7 ? S_PAR : S_DATA) :
             r_state == S_PAR  ? S_STOP : S_IDLE;
  end
  // frame status decoded from the state
  always_comb begin
    w_busy = r_state != S_IDLE;
    w_end  = w_sample && r_state == S_STOP;
    w_good = w_dat && (^{r_shift, r_par});
  end
  // datapath: deserialise, fold prefixes into flags, issue strobes
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_par    <= 1'b0;
      r_brk    <= 1'b0;
      r_ext    <= 1'b0;
      r_code   <= '0;
      r_break  <= 1'b0;
      r_extend <= 1'b0;
      r_valid  <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      r_valid <= w_end && w_good && r_shift != 8'hE0 && r_shift != 8'hF0;
      r_perr  <= (w_end && !w_good) || w_timeout;
      if (w_sample && r_state == S_IDLE) r_bitcnt <= '0;
      if (w_sample && r_state == S_DATA) begin
        r_shift  <= {w_dat, r_shift[7:1]};
        r_bitcnt <= r_bitcnt + 1'b1;
      end
      if (w_sample && r_state == S_PAR) r_par <= w_dat;
      if (w_timeout || (w_end && !w_good)) begin
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end else if (w_end) begin
        if (r_shift == 8'hE0) r_ext <= 1'b1;
        else if (r_shift == 8'hF0) r_brk <= 1'b1;
        else begin
          r_code   <= r_shift;
          r_break  <= r_brk;
          r_extend <= r_ext;
          r_brk    <= 1'b0;
          r_ext    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: scoreboard bench for ps2_kbd_rx with directed PS/2 frames
module tb_ps2_kbd_rx;
  logic       CLK = 0, RST_N = 0, PS2_CLK = 1, PS2_DATA = 1;
  logic [7:0] CODE;
  logic       BREAK, EXTEND, VALID, PERR, BUSY;
  typedef struct {logic perr; logic [7:0] code; logic brk; logic ext;} exp_t;
  exp_t q[$];
  exp_t me;
  int total = 0, bad = 0, cyc = 0, perr_cyc = 0, t_fall = 0;

  ps2_kbd_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(1000)) dut (
    .CLK(CLK), .RST_N(RST_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .CODE(CODE), .BREAK(BREAK), .EXTEND(EXTEND), .VALID(VALID), .PERR(PERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic pv(logic [7:0] c, logic b, logic x);
    q.push_back('{1'b0, c, b, x});
  endtask

  task automatic pe(logic [7:0] c, logic b, logic x);
    q.push_back('{1'b1, c, b, x});
  endtask

  // nb bits of frame {stop, parity^pf, d, start}; gl adds a 3-cycle low glitch in bit 3's high phase
  task automatic send(logic [7:0] d, logic pf, logic st, logic gl, int nb);
    logic [10:0] f;
    f = {st, (~^d) ^ pf, d, 1'b0};
    for (int i = 0; i < nb; i++) begin
      @(negedge CLK) PS2_DATA = f[i];
      repeat (10) @(negedge CLK);
      if (gl && i == 3) begin
        PS2_CLK = 0;
        repeat (3) @(negedge CLK);
        PS2_CLK = 1;
        repeat (7) @(negedge CLK);
      end else repeat (10) @(negedge CLK);
      PS2_CLK = 0;
      t_fall = cyc;
      repeat (40) @(negedge CLK);
      PS2_CLK = 1;
      repeat (20) @(negedge CLK);
    end
    PS2_DATA = 1;
    repeat (20) @(negedge CLK);
  endtask

  task automatic good(logic [7:0] d);
    send(d, 1'b0, 1'b1, 1'b0, 11);
  endtask

  always @(negedge CLK) begin
    if (RST_N && (VALID || PERR)) begin
      if (PERR) perr_cyc = cyc;
      chk("valid_perr_excl", int'(VALID & PERR), 0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: valid=%b perr=%b code=%h, expected no strobe", VALID, PERR, CODE);
      end else begin
        me = q.pop_front();
        chk("strobe_kind_perr", int'(PERR), int'(me.perr));
        chk("code", int'(CODE), int'(me.code));
        chk("break", int'(BREAK), int'(me.brk));
        chk("extend", int'(EXTEND), int'(me.ext));
      end
    end
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_code", CODE, 0);
    chk("rst_busy", BUSY, 0);
    RST_N = 1;
    repeat (5) @(negedge CLK);
    chk("rst_break", BREAK, 0);
    chk("rst_extend", EXTEND, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_perr", PERR, 0);
    pv(8'h1C, 0, 0); good(8'h1C);
    chk("busy_idle", BUSY, 0);
    pv(8'h1C, 1, 0); good(8'hF0); good(8'h1C);
    pv(8'h1C, 0, 0); good(8'h1C);
    pv(8'h75, 1, 1); good(8'hE0); good(8'hF0); good(8'h75);
    pe(8'h75, 1, 1); send(8'h1C, 1'b1, 1'b1, 1'b0, 11);
    pe(8'h75, 1, 1); send(8'h1C, 1'b0, 1'b0, 1'b0, 11);
    chk("code_kept", CODE, 8'h75);
    pv(8'h32, 0, 0); good(8'h32);
    pe(8'h32, 0, 0); good(8'hF0); send(8'h1C, 1'b1, 1'b1, 1'b0, 11);
    pv(8'h1C, 0, 0); good(8'h1C);
    pv(8'h1C, 1, 0); good(8'hF0); good(8'hF0); good(8'h1C);
    @(negedge CLK) PS2_CLK = 0;
    repeat (3) @(negedge CLK);
    PS2_CLK = 1;
    repeat (20) @(negedge CLK);
    pv(8'h1C, 0, 0); send(8'h1C, 1'b0, 1'b1, 1'b1, 11);
    chk("glitch_idle", BUSY, 0);
    send(8'h1C, 1'b0, 1'b1, 1'b0, 5);
`ifdef PS2_RX_TIMEOUT_EN
    pe(8'h1C, 0, 0);
    repeat (1100) @(negedge CLK);
    chk("timeout_window", int'((perr_cyc - t_fall) >= 1009 && (perr_cyc - t_fall) <= 1013), 1);
    chk("timeout_busy", BUSY, 0);
    pv(8'h1C, 0, 0); good(8'h1C);
    send(8'h1C, 1'b0, 1'b1, 1'b0, 5);
`else
    repeat (1100) @(negedge CLK);
`endif
    chk("trunc_busy", BUSY, 1);
    RST_N = 0;
    #1;
    chk("mid_rst_code", CODE, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_break", BREAK, 0);
    chk("mid_rst_valid", VALID, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1;
    pv(8'h1C, 0, 0); good(8'h1C);
    repeat (50) @(negedge CLK);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
